// File: rtl/seq_alu_bcd_display_if.sv
// Operand/opcode request bus and result/display bus of seq_alu_bcd_display.
// master: the front end that issues operations; slave: the ALU itself.
interface seq_alu_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [2:0]            opcode;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  neg;
  logic [2*WIDTH-1:0]    result;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, opcode, operand_a, operand_b,
    input  busy, done, err, neg, result, seg
  );

  modport slave (
    input  start, opcode, operand_a, operand_b,
    output busy, done, err, neg, result, seg
  );
endinterface

// File: rtl/seq_alu_bcd_display.sv
// Multi-cycle ALU with registered 7-segment output.
// IDLE -> EXEC (1 cycle, or WIDTH cycles for MUL/DIV/MOD) -> BCD (2*WIDTH
// double-dabble shifts plus one cycle to render the digits) -> DONE -> IDLE.
// Optional macro SIGNED_DISPLAY_EN: show a minus digit left of a negative
// SUB magnitude.
module seq_alu_bcd_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_alu_bcd_display_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(RW + 1);
`ifdef SIGNED_DISPLAY_EN
  localparam bit SHOW_SIGN = 1'b1;
`else
  localparam bit SHOW_SIGN = 1'b0;
`endif
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [RW-1:0]        prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d;
  logic [RW-1:0]        res_q, res_d, bin_q, bin_d, result_q, result_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 negp_q, negp_d, errp_q, errp_d;
  logic                 neg_q, neg_d, err_q, err_d;
  logic [SW-1:0]        seg_q, seg_d;

  logic [WIDTH:0]       div_shift;
  logic [RW-1:0]        alu_res;
  logic                 exec_last;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1111110;
      4'd1:    dec7 = 7'b0110000;
      4'd2:    dec7 = 7'b1101101;
      4'd3:    dec7 = 7'b1111001;
      4'd4:    dec7 = 7'b0110011;
      4'd5:    dec7 = 7'b1011011;
      4'd6:    dec7 = 7'b1011111;
      4'd7:    dec7 = 7'b1110000;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1111011;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] bcd);
    logic [BW-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Digit rendering with leading-zero blanking; digit 0 is always shown.
  function automatic logic [SW-1:0] render(input logic [BW-1:0] bcd,
                                           input logic neg, input logic err);
    logic [SW-1:0] s;
    int msd;
    s   = '0;
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      if (err)                                 s[7*i +: 7] = SEG_MINUS;
      else if (i <= msd)                       s[7*i +: 7] = dec7(bcd[4*i +: 4]);
      else if (SHOW_SIGN && neg && i == msd+1) s[7*i +: 7] = SEG_MINUS;
    end
    return s;
  endfunction

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;
  assign bus.neg    = neg_q;
  assign bus.result = result_q;
  assign bus.seg    = seg_q;

  // Next-state, iterative datapath steps and output updates.
  always_comb begin
    state_d  = state_q;  cnt_d    = cnt_q;
    a_d      = a_q;      b_d      = b_q;      op_d  = op_q;
    prod_d   = prod_q;   mcand_d  = mcand_q;  mplier_d = mplier_q;
    rem_d    = rem_q;    quo_d    = quo_q;
    res_d    = res_q;    bin_d    = bin_q;    bcd_d = bcd_q;
    negp_d   = negp_q;   errp_d   = errp_q;
    result_d = result_q; neg_d    = neg_q;    err_d = err_q;
    seg_d    = seg_q;
    alu_res  = '0;
    exec_last = 1'b0;
    div_shift = {rem_q, quo_q[WIDTH-1]};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.operand_a;
          b_d      = bus.operand_b;
          op_d     = bus.opcode;
          prod_d   = '0;
          mcand_d  = RW'(bus.operand_a);
          mplier_d = bus.operand_b;
          rem_d    = '0;
          quo_d    = bus.operand_a;
          cnt_d    = '0;
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        if (op_q >= 3'd5) begin
          // One shift-add multiply step and one restoring divide step.
          prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (div_shift >= {1'b0, b_q}) begin
            rem_d = WIDTH'(div_shift - {1'b0, b_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d     = cnt_q + CW'(1);
          exec_last = (cnt_q == CW'(WIDTH - 1));
        end else begin
          exec_last = 1'b1;
        end

        case (op_q)
          3'd0: alu_res = RW'({1'b0, a_q} + {1'b0, b_q});
          3'd1: alu_res = RW'((a_q >= b_q) ? (a_q - b_q) : (b_q - a_q));
          3'd2: alu_res = RW'(a_q & b_q);
          3'd3: alu_res = RW'(a_q | b_q);
          3'd4: alu_res = RW'(a_q ^ b_q);
          3'd5: alu_res = prod_d;
          3'd6: alu_res = (b_q == '0) ? '1 : RW'(quo_d);
          default: alu_res = (b_q == '0) ? '1 : RW'(rem_d);
        endcase

        if (exec_last) begin
          res_d   = alu_res;
          bin_d   = alu_res;
          bcd_d   = '0;
          negp_d  = (op_q == 3'd1) && (a_q < b_q);
          errp_d  = (op_q >= 3'd6) && (b_q == '0);
          cnt_d   = '0;
          state_d = S_BCD;
        end
      end

      S_BCD: begin
        if (cnt_q == CW'(RW)) begin
          result_d = res_q;
          neg_d    = negp_q;
          err_d    = errp_q;
          seg_d    = render(bcd_q, negp_q, errp_q);
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          {bcd_d, bin_d} = {dabble(bcd_q), bin_q} << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q    <= '0;
      a_q     <= '0;      b_q      <= '0;  op_q <= '0;
      prod_q  <= '0;      mcand_q  <= '0;  mplier_q <= '0;
      rem_q   <= '0;      quo_q    <= '0;
      res_q   <= '0;      bin_q    <= '0;  bcd_q <= '0;
      negp_q  <= 1'b0;    errp_q   <= 1'b0;
      result_q <= '0;     neg_q    <= 1'b0; err_q <= 1'b0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d; cnt_q    <= cnt_d;
      a_q     <= a_d;     b_q      <= b_d;  op_q <= op_d;
      prod_q  <= prod_d;  mcand_q  <= mcand_d; mplier_q <= mplier_d;
      rem_q   <= rem_d;   quo_q    <= quo_d;
      res_q   <= res_d;   bin_q    <= bin_d; bcd_q <= bcd_d;
      negp_q  <= negp_d;  errp_q   <= errp_d;
      result_q <= result_d; neg_q  <= neg_d; err_q <= err_d;
      seg_q   <= seg_d;
    end
  end
endmodule

// File: tb/tb_seq_alu_bcd_display.sv
// Directed bench for seq_alu_bcd_display (WIDTH=8, DIGITS=6).
module tb_seq_alu_bcd_display;
  localparam logic [6:0] BL = 7'b0000000;
  localparam logic [6:0] MN = 7'b0000001;
  localparam logic [6:0] D0 = 7'b1111110, D1 = 7'b0110000, D2 = 7'b1101101;
  localparam logic [6:0] D3 = 7'b1111001, D4 = 7'b0110011, D5 = 7'b1011011;
  localparam logic [6:0] D6 = 7'b1011111, D7 = 7'b1110000, D8 = 7'b1111111;
  localparam logic [6:0] D9 = 7'b1111011;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_alu_bcd_display_if #(.WIDTH(8), .DIGITS(6)) bus();

  seq_alu_bcd_display #(.WIDTH(8), .DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        neg;
    logic        err;
    logic [41:0] seg;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for done; lat = edges from sampling edge.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    int first_lat;
    logic [15:0] first_res;
    logic [41:0] sub_seg;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.opcode = 3'd0; bus.operand_a = '0; bus.operand_b = '0;

`ifdef SIGNED_DISPLAY_EN
    sub_seg = {BL, BL, BL, BL, MN, D4};
`else
    sub_seg = {BL, BL, BL, BL, BL, D4};
`endif

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'd300,   1'b0, 1'b0, {BL, BL, BL, D3, D0, D0}, 18};
    vecs[1]  = '{3'd1, 8'd5,   8'd9,   16'd4,     1'b1, 1'b0, sub_seg,                  18};
    vecs[2]  = '{3'd5, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, {BL, D6, D5, D0, D2, D5}, 25};
    vecs[3]  = '{3'd6, 8'd200, 8'd7,   16'd28,    1'b0, 1'b0, {BL, BL, BL, BL, D2, D8}, 25};
    vecs[4]  = '{3'd7, 8'd200, 8'd7,   16'd4,     1'b0, 1'b0, {BL, BL, BL, BL, BL, D4}, 25};
    vecs[5]  = '{3'd6, 8'd200, 8'd0,   16'hFFFF,  1'b0, 1'b1, {MN, MN, MN, MN, MN, MN}, 25};
    vecs[6]  = '{3'd2, 8'hF0,  8'h3C,  16'd48,    1'b0, 1'b0, {BL, BL, BL, BL, D4, D8}, 18};
    vecs[7]  = '{3'd3, 8'hF0,  8'h0F,  16'd255,   1'b0, 1'b0, {BL, BL, BL, D2, D5, D5}, 18};
    vecs[8]  = '{3'd4, 8'hAA,  8'hFF,  16'd85,    1'b0, 1'b0, {BL, BL, BL, BL, D8, D5}, 18};
    vecs[9]  = '{3'd1, 8'd9,   8'd9,   16'd0,     1'b0, 1'b0, {BL, BL, BL, BL, BL, D0}, 18};
    vecs[10] = '{3'd0, 8'd255, 8'd255, 16'd510,   1'b0, 1'b0, {BL, BL, BL, D5, D1, D0}, 18};
    vecs[11] = '{3'd7, 8'd13,  8'd0,   16'hFFFF,  1'b0, 1'b1, {MN, MN, MN, MN, MN, MN}, 25};
    vecs[12] = '{3'd1, 8'd250, 8'd3,   16'd247,   1'b0, 1'b0, {BL, BL, BL, D2, D4, D7}, 18};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_err",    64'(bus.err),    64'd0);
    chk("rst_neg",    64'(bus.neg),    64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_seg",    64'(bus.seg),    64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Table of operations, each started in the cycle right after the previous done
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat),        64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i),  64'(bus.result), 64'(vecs[i].res));
      chk($sformatf("v%0d_neg", i),     64'(bus.neg),    64'(vecs[i].neg));
      chk($sformatf("v%0d_err", i),     64'(bus.err),    64'(vecs[i].err));
      chk($sformatf("v%0d_seg", i),     64'(bus.seg),    64'(vecs[i].seg));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), 64'({bus.busy, bus.done}), 64'd0);
    end

    // A second start during MUL EXEC is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd5; bus.operand_a = 8'd255; bus.operand_b = 8'd255;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0; first_lat = -1; first_res = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 4) begin
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 3'd0; bus.operand_a = 8'd1; bus.operand_b = 8'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first_lat < 0) begin
          first_lat = k;
          first_res = bus.result;
        end
      end
    end
    chk("ign_done_count", 64'(dones),     64'd1);
    chk("ign_latency",    64'(first_lat), 64'd25);
    chk("ign_result",     64'(first_res), 64'd65025);

    // Reset mid-BCD aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd0; bus.operand_a = 8'd200; bus.operand_b = 8'd100;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy",   64'(bus.busy),   64'd0);
    chk("midrst_done",   64'(bus.done),   64'd0);
    chk("midrst_seg",    64'(bus.seg),    64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_neg",    64'(bus.neg),    64'd0);
    chk("midrst_err",    64'(bus.err),    64'd0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    do_op(3'd0, 8'd1, 8'd1, lat);
    chk("post_latency", 64'(lat),        64'd18);
    chk("post_result",  64'(bus.result), 64'd2);
    chk("post_seg",     64'(bus.seg),    64'({BL, BL, BL, BL, BL, D2}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
